// File: rtl/fwrisc_rf_ctrl.sv
// Register-file port initiator: operand fetch, execute handshake and writeback for fwrisc.
// Optional read/writeback overlap with bypass is enabled by defining FWRISC_RF_OVERLAP_EN.
module fwrisc_rf_ctrl #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_rs1,
    input  logic [ADDR_BITS-1:0] req_rs2,
    input  logic [ADDR_BITS-1:0] req_rd,

    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DATA_BITS-1:0] op_a,
    output logic [DATA_BITS-1:0] op_b,

    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic                 wb_wen,
    input  logic [DATA_BITS-1:0] wb_data,

    output logic [ADDR_BITS-1:0] ra_raddr,
    input  logic [DATA_BITS-1:0] ra_rdata,
    output logic [ADDR_BITS-1:0] rb_raddr,
    input  logic [DATA_BITS-1:0] rb_rdata,

    output logic [ADDR_BITS-1:0] rd_waddr,
    output logic [DATA_BITS-1:0] rd_wdata,
    output logic                 rd_wen,
    output logic                 instr_complete
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [ADDR_BITS-1:0]   rs1_q;
    logic [ADDR_BITS-1:0]   rs2_q;
    logic [ADDR_BITS-1:0]   rd_q;
    logic                   req_accept;
    logic                   rd_nonzero;

`ifdef FWRISC_RF_OVERLAP_EN
    logic                   byp_a_q;
    logic                   byp_b_q;
    logic [DATA_BITS-1:0]   wb_data_q;
    logic                   retire_fwd;
`endif

    assign req_accept = req_valid && req_ready;
    assign rd_nonzero = (rd_q != '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = EXEC;
                end
                EXEC: begin
                    if (op_ready) begin
                        state_d = WB;
                    end
                end
                WB: begin
                    if (wb_valid) begin
`ifdef FWRISC_RF_OVERLAP_EN
                        state_d = req_valid ? FETCH : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic: handshake readies, regfile addresses and the writeback strobe
    always_comb begin
        req_ready      = 1'b0;
        wb_ready       = 1'b0;
        ra_raddr       = rs1_q;
        rb_raddr       = rs2_q;
        rd_waddr       = rd_q;
        rd_wdata       = wb_data;
        rd_wen         = 1'b0;
        instr_complete = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                ra_raddr  = req_rs1;
                rb_raddr  = req_rs2;
            end
            WB: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    rd_wen         = wb_wen && rd_nonzero;
                    instr_complete = 1'b1;
                end
`ifdef FWRISC_RF_OVERLAP_EN
                req_ready = wb_valid;
                ra_raddr  = req_rs1;
                rb_raddr  = req_rs2;
`endif
            end
            default: begin
            end
        endcase
        // An instruction caught by reset must not retire or write
        if (reset) begin
            wb_ready       = 1'b0;
            rd_wen         = 1'b0;
            instr_complete = 1'b0;
        end
    end

`ifdef FWRISC_RF_OVERLAP_EN
    // The retiring result is forwarded when it targets a real register and is written
    assign retire_fwd = (state_q == WB) && wb_wen && rd_nonzero;
`endif

    // Request address capture
    always_ff @(posedge clock) begin
        if (reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
        end else if (req_accept) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            rd_q  <= req_rd;
        end
    end

`ifdef FWRISC_RF_OVERLAP_EN
    // Bypass flags: the regfile read issued on a WB-accept edge misses the concurrent write
    always_ff @(posedge clock) begin
        if (reset) begin
            byp_a_q   <= 1'b0;
            byp_b_q   <= 1'b0;
            wb_data_q <= '0;
        end else if (req_accept) begin
            byp_a_q   <= retire_fwd && (req_rs1 == rd_q);
            byp_b_q   <= retire_fwd && (req_rs2 == rd_q);
            wb_data_q <= wb_data;
        end
    end
`endif

    // Operand capture and execute-side valid
    always_ff @(posedge clock) begin
        if (reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (state_q == FETCH) begin
            op_valid <= 1'b1;
`ifdef FWRISC_RF_OVERLAP_EN
            op_a     <= byp_a_q ? wb_data_q : ra_rdata;
            op_b     <= byp_b_q ? wb_data_q : rb_rdata;
`else
            op_a     <= ra_rdata;
            op_b     <= rb_rdata;
`endif
        end else if ((state_q == EXEC) && op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwrisc_rf_ctrl.sv
// Directed self-checking bench for fwrisc_rf_ctrl with a 1-cycle registered regfile model.
// Overlap/bypass checks are compiled in when FWRISC_RF_OVERLAP_EN is defined.
module tb_fwrisc_rf_ctrl;

    localparam int unsigned ADDR_BITS = 6;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned NREGS     = 64;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_rs1;
    logic [ADDR_BITS-1:0] req_rs2;
    logic [ADDR_BITS-1:0] req_rd;
    logic                 op_valid;
    logic                 op_ready;
    logic [DATA_BITS-1:0] op_a;
    logic [DATA_BITS-1:0] op_b;
    logic                 wb_valid;
    logic                 wb_ready;
    logic                 wb_wen;
    logic [DATA_BITS-1:0] wb_data;
    logic [ADDR_BITS-1:0] ra_raddr;
    logic [DATA_BITS-1:0] ra_rdata;
    logic [ADDR_BITS-1:0] rb_raddr;
    logic [DATA_BITS-1:0] rb_rdata;
    logic [ADDR_BITS-1:0] rd_waddr;
    logic [DATA_BITS-1:0] rd_wdata;
    logic                 rd_wen;
    logic                 instr_complete;

    logic                 preload;
    logic [DATA_BITS-1:0] regs [NREGS];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc_c1 = 0;

    fwrisc_rf_ctrl #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_rd         (req_rd),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_wen         (wb_wen),
        .wb_data        (wb_data),
        .ra_raddr       (ra_raddr),
        .ra_rdata       (ra_rdata),
        .rb_raddr       (rb_raddr),
        .rb_rdata       (rb_rdata),
        .rd_waddr       (rd_waddr),
        .rd_wdata       (rd_wdata),
        .rd_wen         (rd_wen),
        .instr_complete (instr_complete)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Regfile model: registered reads return the pre-write value on a colliding edge
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
            regs[1] <= 32'h5;
            regs[2] <= 32'h7;
            regs[4] <= 32'h44;
            regs[5] <= 32'h55;
        end else if (rd_wen) begin
            regs[rd_waddr] <= rd_wdata;
        end
        ra_rdata <= regs[ra_raddr];
        rb_rdata <= regs[rb_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input int rs1, input int rs2, input int rd);
        req_valid = 1'b1;
        req_rs1   = ADDR_BITS'(rs1);
        req_rs2   = ADDR_BITS'(rs2);
        req_rd    = ADDR_BITS'(rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        preload   = 1'b1;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_rd    = '0;
        op_ready  = 1'b0;
        wb_valid  = 1'b0;
        wb_wen    = 1'b0;
        wb_data   = '0;
        step();
        step();
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rd_wen", 32'(rd_wen), 32'd0);
        check("rst_complete", 32'(instr_complete), 32'd0);

        // Basic fetch: rs1=1, rs2=2, rd=3
        reset   = 1'b0;
        preload = 1'b0;
        request(1, 2, 3);
        #1;
        check("idle_ra_raddr", 32'(ra_raddr), 32'd1);
        check("idle_rb_raddr", 32'(rb_raddr), 32'd2);
        step();
        req_valid = 1'b0;
        check("fetch_op_valid", 32'(op_valid), 32'd0);
        check("fetch_req_ready", 32'(req_ready), 32'd0);
        check("fetch_ra_held", 32'(ra_raddr), 32'd1);
        step();
        check("exec_op_valid", 32'(op_valid), 32'd1);
        check("exec_op_a", op_a, 32'h5);
        check("exec_op_b", op_b, 32'h7);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        check("wb_op_valid", 32'(op_valid), 32'd0);
        check("wb_ready", 32'(wb_ready), 32'd1);
        check("wb_idle_rd_wen", 32'(rd_wen), 32'd0);
        check("wb_idle_complete", 32'(instr_complete), 32'd0);
        step();
        check("wb_hold_ready", 32'(wb_ready), 32'd1);
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'hC;
`ifndef FWRISC_RF_OVERLAP_EN
        request(9, 9, 9);
        #1;
        check("wb_no_overlap_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
`endif
        #1;
        check("wb_rd_wen", 32'(rd_wen), 32'd1);
        check("wb_rd_waddr", 32'(rd_waddr), 32'd3);
        check("wb_rd_wdata", rd_wdata, 32'hC);
        check("wb_complete", 32'(instr_complete), 32'd1);
        step();
        wb_valid = 1'b0;
        wb_wen   = 1'b0;
        check("back_idle_ready", 32'(req_ready), 32'd1);
        check("back_idle_rd_wen", 32'(rd_wen), 32'd0);
        check("back_idle_complete", 32'(instr_complete), 32'd0);
        check("reg3_written", regs[3], 32'hC);

        // rd=0 writeback and op_ready stall; rs1=3 also reads back the previous write
        request(3, 1, 0);
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_op_valid", 32'(op_valid), 32'd1);
            check("stall_op_a", op_a, 32'hC);
            check("stall_op_b", op_b, 32'h5);
            step();
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'h77;
        #1;
        check("rd0_rd_wen", 32'(rd_wen), 32'd0);
        check("rd0_complete", 32'(instr_complete), 32'd1);
        step();
        wb_valid = 1'b0;
        wb_wen   = 1'b0;
        check("rd0_reg0", regs[0], 32'd0);

        // Reset while in EXEC with a stray writeback offered
        request(1, 2, 6);
        step();
        req_valid = 1'b0;
        step();
        check("pre_rst_op_valid", 32'(op_valid), 32'd1);
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'hDEAD;
        step();
        reset    = 1'b0;
        wb_valid = 1'b0;
        wb_wen   = 1'b0;
        check("midrst_op_valid", 32'(op_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_op_a", op_a, 32'd0);
        step();
        check("midrst_reg6", regs[6], 32'd0);

`ifdef FWRISC_RF_OVERLAP_EN
        // I1: rs1=5 rs2=1 rd=4
        request(5, 1, 4);
        step();
        req_valid = 1'b0;
        step();
        check("ov_i1_op_a", op_a, 32'h55);
        check("ov_i1_op_b", op_b, 32'h5);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        // I1 retires 0x99 to r4 while I2 (rs1=4 rs2=2 rd=4) is accepted
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'h99;
        request(4, 2, 4);
        #1;
        check("ov_wb_req_ready", 32'(req_ready), 32'd1);
        check("ov_wb_ra_raddr", 32'(ra_raddr), 32'd4);
        check("ov_i1_rd_wen", 32'(rd_wen), 32'd1);
        check("ov_i1_complete", 32'(instr_complete), 32'd1);
        cyc_c1 = cyc;
        step();
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        wb_wen    = 1'b0;
        check("ov_i2_fetch_valid", 32'(op_valid), 32'd0);
        step();
        check("ov_i2_op_a_bypass", op_a, 32'h99);
        check("ov_i2_op_b", op_b, 32'h7);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        // I2 retires 0x11 to r4 while I3 (rs1=4 rs2=4 rd=7) is accepted
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'h11;
        request(4, 4, 7);
        #1;
        check("ov_i2_complete", 32'(instr_complete), 32'd1);
        check("ov_period", 32'(cyc - cyc_c1), 32'd3);
        step();
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        wb_wen    = 1'b0;
        step();
        check("ov_i3_op_a_bypass", op_a, 32'h11);
        check("ov_i3_op_b_bypass", op_b, 32'h11);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_data  = 32'h33;
        #1;
        check("ov_i3_rd_waddr", 32'(rd_waddr), 32'd7);
        step();
        wb_valid = 1'b0;
        wb_wen   = 1'b0;
        check("ov_end_idle", 32'(req_ready), 32'd1);
        check("ov_reg4", regs[4], 32'h11);
        check("ov_reg7", regs[7], 32'h33);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwrisc_rf_ctrl.md
Name: fwrisc_rf_ctrl

Overview:
- Initiator side of the fwrisc register-file port.
- Accepts a decoded operand request (rs1/rs2/rd), issues the two registered regfile reads and captures the returned data.
- Presents operands to the execute stage over a valid/ready handshake, then accepts the writeback result and drives the regfile write port and instr_complete.
- Sits between decode/execute and the register file; is the only driver of the regfile ra_raddr/rb_raddr/rd_* inputs.

Parameters:
- ADDR_BITS, 6, register address width (GPRs 0-31, CSR shadow 32-63).
- DATA_BITS, 32, register data width.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operand request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rs1  in  ADDR_BITS  source A address.
- req_rs2  in  ADDR_BITS  source B address.
- req_rd  in  ADDR_BITS  destination address.
- op_valid  out  1  operands valid.
- op_ready  in  1  execute consumed operands.
- op_a  out  DATA_BITS  source A value.
- op_b  out  DATA_BITS  source B value.
- wb_valid  in  1  writeback result valid.
- wb_ready  out  1  writeback accepted when wb_valid && wb_ready.
- wb_wen  in  1  result is to be written to rd.
- wb_data  in  DATA_BITS  result data.
- ra_raddr  out  ADDR_BITS  regfile read address A.
- ra_rdata  in  DATA_BITS  regfile read data A (1-cycle registered read).
- rb_raddr  out  ADDR_BITS  regfile read address B.
- rb_rdata  in  DATA_BITS  regfile read data B.
- rd_waddr  out  ADDR_BITS  regfile write address.
- rd_wdata  out  DATA_BITS  regfile write data.
- rd_wen  out  1  regfile write enable.
- instr_complete  out  1  one-cycle retire pulse.

Behaviour:
- States: IDLE, FETCH, EXEC, WB. Reset: state=IDLE; op_valid=0; op_a=op_b=0; rd_wen=0; instr_complete=0; rs1_q/rs2_q/rd_q=0.
- IDLE:
  - req_ready=1.
  - ra_raddr=req_rs1, rb_raddr=req_rs2 (combinational), so the regfile samples them on the accept edge.
  - On accept: latch rs1_q/rs2_q/rd_q; go to FETCH.
- Outside IDLE: ra_raddr=rs1_q, rb_raddr=rs2_q.
- FETCH (exactly 1 cycle):
  - ra_rdata/rb_rdata are valid; capture into op_a/op_b registers; go to EXEC.
  - Accept at edge N gives op_valid=1 from cycle N+2.
- EXEC:
  - op_valid=1; op_a/op_b held stable until op_ready.
  - On op_valid && op_ready: op_valid=0 next cycle; go to WB.
- WB:
  - wb_ready=1.
  - On wb_valid (combinational, same cycle): rd_waddr=rd_q, rd_wdata=wb_data, rd_wen=wb_wen && (rd_q!=0), instr_complete=1.
  - Next state IDLE.
- rd_wen and instr_complete are 0 in every other state/cycle.
- rd_q==0: rd_wen is never asserted, but instr_complete still pulses.
- Default (no overlap): write at WB edge precedes the next read edge, so no hazard exists and back-to-back throughput is 1 instr per 4 cycles minimum.
- op_ready held high in EXEC: leaves EXEC after 1 cycle. wb_valid low: WB holds indefinitely.
- Reset mid-operation: return to IDLE next edge; in-flight request discarded; no write or instr_complete issued.

Optional Feature:
- Macro: FWRISC_RF_OVERLAP_EN.
- Defined:
  - req_ready is also 1 in WB when wb_valid=1. An accept there goes directly to FETCH (skips IDLE); ra_raddr/rb_raddr take req_rs*.
  - Bypass: the regfile read on that edge returns stale data. Each source whose address equals the retiring rd_q (nonzero, wb_wen=1) is flagged; FETCH substitutes the latched wb_data for that operand.
  - Result: 3 cycles/instr.
- Undefined: req_ready=0 in WB; no bypass logic.

Test Plan:
- Reset, then req rs1=1, rs2=2, rd=3 with regs[1]=5, regs[2]=7 -> op_valid at accept+2, op_a=5, op_b=7.
- op_ready, then wb_valid with wb_wen=1, wb_data=0xC -> one cycle with rd_wen=1, rd_waddr=3, rd_wdata=0xC, instr_complete=1; state returns to IDLE.
- Writeback with rd=0, wb_wen=1 -> rd_wen stays 0, instr_complete=1.
- op_ready held low 5 cycles in EXEC -> op_valid=1 and op_a/op_b stable throughout.
- Reset asserted in EXEC -> next cycle op_valid=0, req_ready=1, and no rd_wen ever issued.
- With FWRISC_RF_OVERLAP_EN: WB of rd=4 data=0x99 with same-cycle req rs1=4 -> op_a=0x99 (not the stale value); sequence runs at 3 cycles/instr.
